// File: rtl/i2c_reg_target.sv
// rtl/i2c_reg_target.sv - I2C target exposing 16-bit registers; register 0 is a read-only live snapshot
// Optional feature: define I2C_TGT_AUTOINC_EN to auto-increment the pointer after each full register access
module i2c_reg_target #(
   parameter logic [6:0]             I2C_ADDR   = 7'b1001001,
   parameter int                     NUM_REGS   = 4,
   parameter int                     PTR_W      = 2,
   parameter logic [16*NUM_REGS-1:0] RESET_VALS = {16'h7FFF, 16'h8000, 16'h8583, 16'h0000}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             sda_oe,
   input  logic [15:0]      live_data,
   output logic             wr_stb,
   output logic [PTR_W-1:0] wr_addr,
   output logic [15:0]      wr_data,
   output logic             busy
);

   localparam int DEPTH = 2**PTR_W;
   localparam logic [16*DEPTH-1:0] RV_PAD = (16*DEPTH)'(RESET_VALS);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
   } state_t;

   state_t           state_q;
   logic [1:0]       scl_sync_q, sda_sync_q;
   logic             scl_prev_q, sda_prev_q;
   logic [3:0]       bit_cnt_q;
   logic [7:0]       shift_q, tx_q, hi_q;
   logic             byte_sel_q, rw_q, mnack_q;
   logic [PTR_W-1:0] ptr_q, ptr_adv_d;
   logic [15:0]      shadow_q;
   logic [15:0]      regs_q [DEPTH];
   logic [15:0]      rd_cur_d, rd_next_d;

   logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

`ifdef I2C_TGT_AUTOINC_EN
   assign ptr_adv_d = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);
`else
   assign ptr_adv_d = ptr_q;
`endif

   // Register 0 always reads the snapshot taken at the last START
   assign rd_cur_d  = (ptr_q == '0) ? shadow_q : regs_q[ptr_q];
   assign rd_next_d = (ptr_adv_d == '0) ? shadow_q : regs_q[ptr_adv_d];

   // Synchronise the raw bus pins and keep the previous level for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   // Protocol FSM: sample on SCL rise, change SDA drive on SCL fall, START/STOP override all states
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sda_oe     <= 1'b0;
         busy       <= 1'b0;
         wr_stb     <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         ptr_q      <= '0;
         shadow_q   <= '0;
         bit_cnt_q  <= '0;
         byte_sel_q <= 1'b0;
         shift_q    <= '0;
         tx_q       <= '0;
         hi_q       <= '0;
         rw_q       <= 1'b0;
         mnack_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= RV_PAD[16*i +: 16];
      end else begin
         wr_stb <= 1'b0;
         if (start_det) begin
            state_q    <= ADDR;
            bit_cnt_q  <= '0;
            byte_sel_q <= 1'b0;
            sda_oe     <= 1'b0;
            shadow_q   <= live_data;
         end else if (stop_det) begin
            state_q    <= IDLE;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            byte_sel_q <= 1'b0;
         end else begin
            case (state_q)
               ADDR, PTR, WDATA: begin
                  if (scl_rise && bit_cnt_q != 4'd8) begin
                     shift_q   <= {shift_q[6:0], sda_s};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall && bit_cnt_q == 4'd8) begin
                     bit_cnt_q <= '0;
                     if (state_q == ADDR) begin
                        if (shift_q[7:1] == I2C_ADDR) begin
                           state_q <= ADDR_ACK;
                           sda_oe  <= 1'b1;
                           busy    <= 1'b1;
                           rw_q    <= shift_q[0];
                        end else begin
                           state_q <= IDLE;
                           busy    <= 1'b0;
                        end
                     end else if (state_q == PTR) begin
                        if (shift_q < 8'(NUM_REGS)) begin
                           state_q <= PTR_ACK;
                           sda_oe  <= 1'b1;
                           ptr_q   <= shift_q[PTR_W-1:0];
                        end else begin
                           state_q <= WAIT_STOP;
                        end
                     end else begin
                        state_q <= WDATA_ACK;
                        sda_oe  <= 1'b1;
                        if (!byte_sel_q) hi_q <= shift_q;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     byte_sel_q <= 1'b0;
                     if (rw_q) begin
                        state_q <= RDATA;
                        tx_q    <= rd_cur_d[15:8];
                        sda_oe  <= ~rd_cur_d[15];
                     end else begin
                        state_q <= PTR;
                        sda_oe  <= 1'b0;
                     end
                  end
               end
               PTR_ACK: begin
                  if (scl_fall) begin
                     state_q    <= WDATA;
                     sda_oe     <= 1'b0;
                     byte_sel_q <= 1'b0;
                  end
               end
               WDATA_ACK: begin
                  if (scl_rise && byte_sel_q) begin
                     if (ptr_q != '0) begin
                        regs_q[ptr_q] <= {hi_q, shift_q};
                        wr_stb        <= 1'b1;
                        wr_addr       <= ptr_q;
                        wr_data       <= {hi_q, shift_q};
                     end
                     ptr_q <= ptr_adv_d;
                  end else if (scl_fall) begin
                     state_q    <= WDATA;
                     sda_oe     <= 1'b0;
                     byte_sel_q <= ~byte_sel_q;
                  end
               end
               RDATA: begin
                  if (scl_rise && bit_cnt_q != 4'd8) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt_q == 4'd8) begin
                        state_q   <= RDATA_ACK;
                        sda_oe    <= 1'b0;
                        bit_cnt_q <= '0;
                     end else if (bit_cnt_q != 4'd0) begin
                        sda_oe <= ~tx_q[3'd7 - bit_cnt_q[2:0]];
                     end
                  end
               end
               RDATA_ACK: begin
                  if (scl_rise) begin
                     mnack_q <= sda_s;
                  end else if (scl_fall) begin
                     if (mnack_q) begin
                        state_q <= WAIT_STOP;
                        sda_oe  <= 1'b0;
                        if (byte_sel_q) ptr_q <= ptr_adv_d;
                     end else if (!byte_sel_q) begin
                        state_q    <= RDATA;
                        tx_q       <= rd_cur_d[7:0];
                        sda_oe     <= ~rd_cur_d[7];
                        byte_sel_q <= 1'b1;
                     end else begin
                        state_q    <= RDATA;
                        ptr_q      <= ptr_adv_d;
                        tx_q       <= rd_next_d[15:8];
                        sda_oe     <= ~rd_next_d[15];
                        byte_sel_q <= 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_reg_target.sv
// tb/tb_i2c_reg_target.sv - directed bench driving an open-drain I2C master against i2c_reg_target
module tb_i2c_reg_target;
   localparam int Q = 50;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl = 1'b1;
   logic        sda_m = 1'b1;
   logic [15:0] live_data = 16'h0000;
   logic        sda_oe, wr_stb, busy;
   logic [1:0]  wr_addr;
   logic [15:0] wr_data;
   logic        sda_line;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int oe_cycles = 0;
   int busy_cycles = 0;
   logic [1:0]  cap_addr = '0;
   logic [15:0] cap_data = '0;

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_reg_target dut (
      .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
      .live_data(live_data), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   // Count commits and bus activity on the inactive edge
   always @(negedge clk) begin
      if (wr_stb) begin
         wr_cnt   <= wr_cnt + 1;
         cap_addr <= wr_addr;
         cap_data <= wr_data;
      end
      if (sda_oe) oe_cycles <= oe_cycles + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
   end

   // Hard stop if the sequence ever stalls
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
      end
      sda_m = 1'b1; #Q; scl = 1'b1; #Q; ack = ~sda_line; #Q; scl = 1'b0; #Q;
   endtask

   task automatic rd_byte(input logic ack_m, output logic [7:0] b);
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         #Q; scl = 1'b1; #Q; b[i] = sda_line; #Q; scl = 1'b0; #Q;
      end
      sda_m = ~ack_m; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q; sda_m = 1'b1;
   endtask

   initial begin
      logic       a;
      logic [7:0] b;
      logic [7:0] exp3, exp4;
      int         oe0, busy0, wr0;

      // Reset state
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_sda_oe", 32'(sda_oe), 0);
      chk("rst_wr_stb", 32'(wr_stb), 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      chk("rst_wr_data", 32'(wr_data), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      #(4*Q);

      // Write 0x1234 to register 1
      i2c_start();
      wr_byte(8'h92, a); chk("w_addr_ack", 32'(a), 1);
      chk("w_busy", 32'(busy), 1);
      wr_byte(8'h01, a); chk("w_ptr_ack", 32'(a), 1);
      wr_byte(8'h12, a); chk("w_d0_ack", 32'(a), 1);
      chk("w_no_commit_yet", 32'(wr_cnt), 0);
      wr_byte(8'h34, a); chk("w_d1_ack", 32'(a), 1);
      chk("w_stb_count", 32'(wr_cnt), 1);
      chk("w_addr", 32'(cap_addr), 1);
      chk("w_data", 32'(cap_data), 32'h1234);
      i2c_stop(); #Q;
      chk("w_busy_after_stop", 32'(busy), 0);

      // Foreign address is ignored entirely
      oe0 = oe_cycles; busy0 = busy_cycles;
      i2c_start();
      wr_byte(8'h96, a); chk("x_addr_nack", 32'(a), 0);
      wr_byte(8'h55, a); chk("x_data_nack", 32'(a), 0);
      i2c_stop(); #Q;
      chk("x_oe_never", 32'(oe_cycles - oe0), 0);
      chk("x_busy_never", 32'(busy_cycles - busy0), 0);

      // Pointer 0, repeated START, read live snapshot
      live_data = 16'hABCD;
      i2c_start();
      wr_byte(8'h92, a); chk("r0_addr_ack", 32'(a), 1);
      wr_byte(8'h00, a); chk("r0_ptr_ack", 32'(a), 1);
      i2c_start();
      wr_byte(8'h93, a); chk("r0_raddr_ack", 32'(a), 1);
      rd_byte(1'b1, b); chk("r0_msb", 32'(b), 32'hAB);
      rd_byte(1'b0, b); chk("r0_lsb", 32'(b), 32'hCD);
      chk("r0_released", 32'(sda_oe), 0);
      i2c_stop(); #Q;

      // Writes to register 0 are acknowledged but dropped
      wr0 = wr_cnt;
      i2c_start();
      wr_byte(8'h92, a);
      wr_byte(8'h00, a);
      wr_byte(8'h55, a); chk("z_d0_ack", 32'(a), 1);
      wr_byte(8'h66, a); chk("z_d1_ack", 32'(a), 1);
      chk("z_no_stb", 32'(wr_cnt - wr0), 0);
      i2c_stop(); #Q;

      // Set pointer 0, then an out-of-range pointer is refused and leaves it alone
      i2c_start(); wr_byte(8'h92, a); wr_byte(8'h00, a); i2c_stop(); #Q;
      i2c_start();
      wr_byte(8'h92, a); chk("p_addr_ack", 32'(a), 1);
      wr_byte(8'h07, a); chk("p_ptr_nack", 32'(a), 0);
      wr_byte(8'h00, a); chk("p_waitstop_nack", 32'(a), 0);
      i2c_stop(); #Q;
      live_data = 16'h1357;
      i2c_start();
      wr_byte(8'h93, a); chk("p_raddr_ack", 32'(a), 1);
      rd_byte(1'b1, b); chk("p_msb", 32'(b), 32'h13);
      rd_byte(1'b0, b); chk("p_lsb", 32'(b), 32'h57);
      i2c_stop(); #Q;

      // Read 4 bytes from register 3
`ifdef I2C_TGT_AUTOINC_EN
      exp3 = 8'h24; exp4 = 8'h68;
`else
      exp3 = 8'h7F; exp4 = 8'hFF;
`endif
      live_data = 16'h2468;
      i2c_start();
      wr_byte(8'h92, a);
      wr_byte(8'h03, a); chk("s_ptr_ack", 32'(a), 1);
      i2c_start();
      wr_byte(8'h93, a);
      rd_byte(1'b1, b); chk("s_b1", 32'(b), 32'h7F);
      rd_byte(1'b1, b); chk("s_b2", 32'(b), 32'hFF);
      rd_byte(1'b1, b); chk("s_b3", 32'(b), 32'(exp3));
      rd_byte(1'b0, b); chk("s_b4", 32'(b), 32'(exp4));
      i2c_stop(); #Q;

      // Register 1 holds the committed write
      i2c_start(); wr_byte(8'h92, a); wr_byte(8'h01, a);
      i2c_start(); wr_byte(8'h93, a);
      rd_byte(1'b1, b); chk("r1_msb", 32'(b), 32'h12);
      rd_byte(1'b0, b); chk("r1_lsb", 32'(b), 32'h34);
      i2c_stop(); #Q;

      // Reset while driving a 0 bit of register 1
      i2c_start(); wr_byte(8'h92, a); wr_byte(8'h01, a);
      i2c_start(); wr_byte(8'h93, a);
      chk("m_driving", 32'(sda_oe), 1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("m_released", 32'(sda_oe), 0);
      chk("m_busy", 32'(busy), 0);
      @(negedge clk); rst = 1'b0;
      oe0 = oe_cycles;
      rd_byte(1'b1, b); chk("m_ignored_byte", 32'(b), 32'hFF);
      chk("m_ignored_oe", 32'(oe_cycles - oe0), 0);
      i2c_stop(); #Q;
      i2c_start();
      wr_byte(8'h92, a); chk("m_new_addr_ack", 32'(a), 1);
      wr_byte(8'h01, a);
      i2c_start(); wr_byte(8'h93, a);
      rd_byte(1'b1, b); chk("m_r1_msb", 32'(b), 32'h85);
      rd_byte(1'b0, b); chk("m_r1_lsb", 32'(b), 32'h83);
      i2c_stop(); #Q;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
